lookup_table_rw: RTL and testbench

//   Parametrised, run-time writable successor to the fixed 16-entry key->value lookup ROM.

---
 rtl/lookup_table_rw.sv | 135 +++++++++++++
 tb/tb_lookup_table_rw.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/lookup_table_rw.sv
// Run-time writable key->value lookup table.
// After reset the table sweeps every entry to INIT_VAL (one entry per cycle),
// then raises ready and serves one read and one write per cycle. Reads have
// one cycle of latency and return registered data. A same-cycle write to the
// key being read is forwarded to the read data (write-first).
//
// Handshake: a request is accepted on a rising edge where its enable is high
// and ready is high. There is no backpressure once ready is set; requests
// presented while ready is low are dropped without side effects.
module lookup_table_rw #(
  parameter int               KEY_W    = 4,
  parameter int               VAL_W    = 8,
  parameter logic [VAL_W-1:0] INIT_VAL = VAL_W'('hFF)
) (
  input  logic             Clk,
  input  logic             Reset,
  output logic             ready,
  input  logic             rd_en,
  input  logic [KEY_W-1:0] rd_key,
  output logic [VAL_W-1:0] rd_value,
  output logic             rd_valid,
  input  logic             wr_en,
  input  logic [KEY_W-1:0] wr_key,
  input  logic [VAL_W-1:0] wr_value,
  output logic             dbg_state
);

  localparam int DEPTH = 1 << KEY_W;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_q;
  logic [KEY_W-1:0]   ptr_q;
  logic               ready_q;
  logic [VAL_W-1:0]   mem_q [DEPTH];
  logic [VAL_W-1:0]   rd_value_q;
  logic               rd_valid_q;

  // Accepted requests; ready_q is high exactly while in ST_RUN.
  logic               rd_acc;
  logic               wr_acc;
  logic               rd_bypass;

  // Single write port into the table, shared by the sweep and user writes.
  logic               mem_we_d;
  logic [KEY_W-1:0]   mem_waddr_d;
  logic [VAL_W-1:0]   mem_wdata_d;
  logic [VAL_W-1:0]   rd_value_d;

  assign rd_acc    = rd_en & ready_q;
  assign wr_acc    = wr_en & ready_q;
  assign rd_bypass = wr_acc & (wr_key == rd_key);

  // Control FSM: init sweep pointer, state and registered ready.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == {KEY_W{1'b1}}) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_INIT;
          ptr_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Select the table write source: sweep entry during init, user write in run.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_waddr_d = wr_key;
    mem_wdata_d = wr_value;
    if (!Reset) begin
      if (state_q == ST_INIT) begin
        mem_we_d    = 1'b1;
        mem_waddr_d = ptr_q;
        mem_wdata_d = INIT_VAL;
      end else if (wr_acc) begin
        mem_we_d    = 1'b1;
        mem_waddr_d = wr_key;
        mem_wdata_d = wr_value;
      end
    end
  end

  // Table storage; contents are defined by the sweep, so no reset here.
  always_ff @(posedge Clk) begin
    if (mem_we_d) begin
      mem_q[mem_waddr_d] <= mem_wdata_d;
    end
  end

  // Read data source: forward the same-cycle write to the same key.
  always_comb begin
    rd_value_d = mem_q[rd_key];
    if (rd_bypass) begin
      rd_value_d = wr_value;
    end
  end

  // Registered read port; rd_value holds between accepted reads.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_value_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rd_value_q <= rd_value_d;
      end
    end
  end

  assign ready     = ready_q;
  assign rd_value  = rd_value_q;
  assign rd_valid  = rd_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lookup_table_rw.sv
// Bench for lookup_table_rw (KEY_W=4, VAL_W=8, INIT_VAL=8'hFF).
module tb_lookup_table_rw;

  localparam int KEY_W = 4;
  localparam int VAL_W = 8;
  localparam int DEPTH = 16;

  // ---------------- clock / reset / DUT ----------------
  logic             Clk;
  logic             Reset;
  logic             ready;
  logic             rd_en;
  logic [KEY_W-1:0] rd_key;
  logic [VAL_W-1:0] rd_value;
  logic             rd_valid;
  logic             wr_en;
  logic [KEY_W-1:0] wr_key;
  logic [VAL_W-1:0] wr_value;
  logic             dbg_state;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  lookup_table_rw #(
    .KEY_W   (KEY_W),
    .VAL_W   (VAL_W),
    .INIT_VAL(8'hFF)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ready    (ready),
    .rd_en    (rd_en),
    .rd_key   (rd_key),
    .rd_value (rd_value),
    .rd_valid (rd_valid),
    .wr_en    (wr_en),
    .wr_key   (wr_key),
    .wr_value (wr_value),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  logic [VAL_W-1:0] exp_q[$];
  logic [VAL_W-1:0] last_exp;
  logic [VAL_W-1:0] mmem [DEPTH];
  logic             mready;
  int               mcnt;
  int               n_checks;
  int               n_fail;

  typedef struct {
    logic             we;
    logic [KEY_W-1:0] wk;
    logic [VAL_W-1:0] wv;
    logic             re;
    logic [KEY_W-1:0] rk;
    logic [VAL_W-1:0] exp_val;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge, then compare every output against the model.
  task automatic step();
    logic             rst_s;
    logic             exp_v;
    logic [VAL_W-1:0] e;
    rst_s = Reset;
    @(posedge Clk);
    #1;
    if (rst_s) begin
      mcnt   = 0;
      mready = 1'b0;
    end else if (!mready) begin
      mcnt++;
      if (mcnt == DEPTH) mready = 1'b1;
    end
    check("ready", {31'd0, ready}, {31'd0, mready});
    check("dbg_state", {31'd0, dbg_state}, {31'd0, mready});
    exp_v = (exp_q.size() != 0);
    check("rd_valid", {31'd0, rd_valid}, {31'd0, exp_v});
    if (exp_v) begin
      e        = exp_q.pop_front();
      last_exp = e;
    end
    check("rd_value", {24'd0, rd_value}, {24'd0, last_exp});
  endtask

  // Drive one cycle of traffic; push the expected read result if accepted.
  task automatic drive(input logic we, input logic [KEY_W-1:0] wk, input logic [VAL_W-1:0] wv,
                       input logic re, input logic [KEY_W-1:0] rk,
                       input logic use_tab, input logic [VAL_W-1:0] tab_exp);
    wr_en    = we;
    wr_key   = wk;
    wr_value = wv;
    rd_en    = re;
    rd_key   = rk;
    if (re && mready && !Reset) begin
      if (use_tab)             exp_q.push_back(tab_exp);
      else if (we && wk == rk) exp_q.push_back(wv);
      else                     exp_q.push_back(mmem[rk]);
    end
    if (we && mready && !Reset) mmem[wk] = wv;
    step();
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset(input int n);
    Reset  = 1'b1;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    exp_q.delete();
    last_exp = '0;
    for (int i = 0; i < DEPTH; i++) mmem[i] = 8'hFF;
    for (int i = 0; i < n; i++) step();
    Reset = 1'b0;
  endtask

  // Step until the model says ready; optionally hammer key 2 meanwhile.
  task automatic wait_ready(input logic busy);
    int cnt;
    cnt = 0;
    while (!mready && cnt < 40) begin
      drive(busy, 4'd2, 8'h11, busy, 4'd2, 1'b0, '0);
      cnt++;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("init_len", cnt, 16);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    mready   = 1'b0;
    mcnt     = 0;
    last_exp = '0;
    Reset    = 1'b1;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    rd_key   = '0;
    wr_key   = '0;
    wr_value = '0;

    vecs[0] = '{we:1'b1, wk:4'd3, wv:8'h5A, re:1'b0, rk:4'd0, exp_val:8'h00};
    vecs[1] = '{we:1'b0, wk:4'd0, wv:8'h00, re:1'b1, rk:4'd3, exp_val:8'h5A};
    vecs[2] = '{we:1'b0, wk:4'd0, wv:8'h00, re:1'b1, rk:4'd4, exp_val:8'hFF};
    vecs[3] = '{we:1'b1, wk:4'd7, wv:8'h33, re:1'b1, rk:4'd7, exp_val:8'h33};
    vecs[4] = '{we:1'b1, wk:4'd1, wv:8'h10, re:1'b1, rk:4'd2, exp_val:8'hFF};
    vecs[5] = '{we:1'b0, wk:4'd0, wv:8'h00, re:1'b1, rk:4'd1, exp_val:8'h10};
    vecs[6] = '{we:1'b0, wk:4'd0, wv:8'h00, re:1'b1, rk:4'd7, exp_val:8'h33};
    vecs[7] = '{we:1'b0, wk:4'd0, wv:8'h00, re:1'b0, rk:4'd0, exp_val:8'h00};
    vecs[8] = '{we:1'b1, wk:4'd3, wv:8'hA5, re:1'b1, rk:4'd3, exp_val:8'hA5};
    vecs[9] = '{we:1'b0, wk:4'd0, wv:8'h00, re:1'b1, rk:4'd3, exp_val:8'hA5};

    // 1: reset, sweep length, every key reads INIT_VAL
    do_reset(2);
    wait_ready(1'b0);
    for (int k = 0; k < DEPTH; k++) drive(1'b0, '0, '0, 1'b1, 4'(k), 1'b1, 8'hFF);
    idle();

    // 2/3: table-driven write, read, bypass and independent keys
    for (int i = 0; i < 10; i++)
      drive(vecs[i].we, vecs[i].wk, vecs[i].wv, vecs[i].re, vecs[i].rk, 1'b1, vecs[i].exp_val);
    idle();
    idle();

    // 4: traffic during init is ignored
    do_reset(1);
    wait_ready(1'b1);
    drive(1'b0, '0, '0, 1'b1, 4'd2, 1'b1, 8'hFF);
    idle();

    // 5: reset with the sweep pointer at 9 restarts the sweep
    do_reset(1);
    for (int i = 0; i < 9; i++) idle();
    do_reset(1);
    wait_ready(1'b0);

    // 6: written values are wiped by a reset
    drive(1'b1, 4'd15, 8'h80, 1'b0, '0, 1'b0, '0);
    drive(1'b1, 4'd0, 8'h01, 1'b1, 4'd15, 1'b1, 8'h80);
    drive(1'b0, '0, '0, 1'b1, 4'd0, 1'b1, 8'h01);
    do_reset(1);
    wait_ready(1'b0);
    drive(1'b0, '0, '0, 1'b1, 4'd15, 1'b1, 8'hFF);
    drive(1'b0, '0, '0, 1'b1, 4'd0, 1'b1, 8'hFF);
    idle();

    // Random back-to-back traffic against the memory model
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, DEPTH - 1)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, DEPTH - 1)), 1'b0, '0);
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
